pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Program counter stage for the KGP-RISC datapath.
- Combines the PC register (holds the current instruction address and the previous one) with a combinational +STEP incrementer.
- The incrementer output is the default next address; an external load (branch/jump target) overrides it.
- Sits at the front of the fetch stage and drives the instruction-memory address.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_VAL, 0, value loaded into the PC and the previous-PC register on reset.
- STEP, 4, increment added per sequential instruction (byte addressing, 32-bit instructions).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  advance enable; 0 = stall (hold all state).
- load  input  1  1 = take load_addr as the next PC instead of the sequential address.
- load_addr  input  WIDTH  branch/jump target address.
- out  output  WIDTH  current PC, registered.
- old_val  output  WIDTH  PC value before the most recent update, registered.
- pc_next_seq  output  WIDTH  combinational out + STEP (the incrementer result).

Behaviour:
- One clock domain (clk); reset is synchronous and active-high; no asynchronous paths.
- Reset: on a rising edge with rst=1, out <= RESET_VAL and old_val <= RESET_VAL. rst has priority over en and load.
- Before the first reset edge, out and old_val are unspecified; the system must assert reset before use.
- Normal update: on a rising edge with rst=0 and en=1:
  - old_val <= out;
  - out <= load ? load_addr : pc_next_seq.
- Stall: on a rising edge with rst=0 and en=0, out and old_val hold; load is ignored.
- Incrementer:
  - pc_next_seq = (out + STEP) mod 2^WIDTH, purely combinational, zero latency.
  - Follows out within the same cycle.
- Latency: a load or sequential step is visible on out one cycle after the edge that samples it; old_val shows the pre-edge out value in the same cycle.
- Wrap-around: out = 2^WIDTH - STEP with a sequential step gives out = 0, with no flag.
- Load with en=1 and load_addr equal to out: out stays the same, and old_val still updates to that value.
- Reset mid-run (rst=1 with en=1, load=1): reset wins; both registers become RESET_VAL on that edge.
- Deassertion of rst: the first edge with rst=0 and en=1 moves out to RESET_VAL + STEP and old_val to RESET_VAL.
- load_addr is accepted unmodified unless the optional feature is compiled in.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined:
  - Adds output misalign (1 bit, registered).
  - On an edge that takes load_addr (rst=0, en=1, load=1), misalign <= |load_addr[1:0]| (any nonzero low 2 bits).
  - The stored out has its low 2 bits forced to 0.
  - misalign clears on reset and on any update edge that does not take a misaligned load.
  - misalign holds during a stall.
- When undefined: no misalign port; load_addr is stored verbatim.

Test Plan:
- Reset then free-run: with en=1 and load=0, hold rst=1 for one edge, then release. Required on successive edges: out = 0, 4, 8, 12, with old_val = 0, 0, 4, 8 and pc_next_seq = out+4 every cycle.
- Stall: at out=8, drive en=0 for 3 edges. Required: out stays 8, old_val stays 4. Then en=1 gives out=12, old_val=8.
- Branch load: at out=12, drive load=1 and load_addr=0x100 for one edge. Required: out=0x100, old_val=12. The next edge with load=0 gives out=0x104.
- Wrap: load 0xFFFFFFFC, then one sequential edge. Required: out=0x00000000, old_val=0xFFFFFFFC, and pc_next_seq=0 while out=0xFFFFFFFC.
- Reset priority: at out=0x104, drive rst=1, en=1, load=1, load_addr=0x200. Required after the edge: out=0, old_val=0.
- PC_ALIGN_CHECK_EN defined: load 0x102. Required: out=0x100, misalign=1. The next sequential edge gives out=0x104, misalign=0.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter stage: PC and previous-PC registers plus a combinational +STEP incrementer; updates one edge after sampling, holds while en=0.
// Optional PC_ALIGN_CHECK_EN: word-aligns loaded targets and flags misaligned loads on a registered misalign output.
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               STEP      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] old_val,
`ifdef PC_ALIGN_CHECK_EN
  output logic             misalign,
`endif
  output logic [WIDTH-1:0] pc_next_seq
);

  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] next_pc;

  assign pc_next_seq = out + WIDTH'(STEP);

`ifdef PC_ALIGN_CHECK_EN
  // Targets are forced onto a 4-byte boundary; the dropped bits are reported instead.
  assign load_val = {load_addr[WIDTH-1:2], 2'b00};
`else
  assign load_val = load_addr;
`endif

  assign next_pc = load ? load_val : pc_next_seq;

  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= RESET_VAL;
      old_val <= RESET_VAL;
    end else if (en) begin
      out     <= next_pc;
      old_val <= out;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign <= 1'b0;
    end else if (en) begin
      misalign <= load & (|load_addr[1:0]);
    end
  end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: stimulus queues expected post-edge state, a negedge monitor pops and compares.
module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [31:0] load_addr;
  logic [31:0] out;
  logic [31:0] old_val;
  logic [31:0] pc_next_seq;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign;
`endif

  pc_unit #(.WIDTH(32), .RESET_VAL(32'h0), .STEP(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load        (load),
    .load_addr   (load_addr),
    .out         (out),
    .old_val     (old_val),
`ifdef PC_ALIGN_CHECK_EN
    .misalign    (misalign),
`endif
    .pc_next_seq (pc_next_seq)
  );

  typedef struct {
    string       name;
    logic [31:0] o;
    logic [31:0] ov;
    logic [31:0] ns;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
    end
  endtask

  // Monitor: outputs are stable at the negedge following each sampled edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      check(cur.name, "out",         out,         cur.o);
      check(cur.name, "old_val",     old_val,     cur.ov);
      check(cur.name, "pc_next_seq", pc_next_seq, cur.ns);
`ifdef PC_ALIGN_CHECK_EN
      check(cur.name, "misalign",    {31'd0, misalign}, {31'd0, cur.mis});
`endif
    end
  end

  task automatic step(input string nm, input logic r, input logic e, input logic l,
                      input logic [31:0] a, input logic [31:0] eo, input logic [31:0] eov,
                      input logic emis);
    exp_t x;
    rst = r; en = e; load = l; load_addr = a;
    @(posedge clk);
    x.name = nm; x.o = eo; x.ov = eov; x.ns = eo + 32'd4; x.mis = emis;
    exp_q.push_back(x);
    #2;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b0; load_addr = 32'h0;
    @(negedge clk);

    step("reset",      1, 1, 0, 32'h0,        32'h0,        32'h0,        0);
    step("run1",       0, 1, 0, 32'h0,        32'h4,        32'h0,        0);
    step("run2",       0, 1, 0, 32'h0,        32'h8,        32'h4,        0);
    step("stall1",     0, 0, 0, 32'h0,        32'h8,        32'h4,        0);
    step("stall2",     0, 0, 1, 32'h40,       32'h8,        32'h4,        0);
    step("stall3",     0, 0, 0, 32'h0,        32'h8,        32'h4,        0);
    step("resume",     0, 1, 0, 32'h0,        32'hC,        32'h8,        0);
    step("branch",     0, 1, 1, 32'h100,      32'h100,      32'hC,        0);
    step("after_br",   0, 1, 0, 32'h0,        32'h104,      32'h100,      0);
    step("rst_prio",   1, 1, 1, 32'h200,      32'h0,        32'h0,        0);
    step("post_rst",   0, 1, 0, 32'h0,        32'h4,        32'h0,        0);
    step("load_same",  0, 1, 1, 32'h4,        32'h4,        32'h4,        0);
    step("load_top",   0, 1, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h4,        0);
    step("wrap",       0, 1, 0, 32'h0,        32'h0,        32'hFFFFFFFC, 0);
    step("stall_ld",   0, 0, 1, 32'h500,      32'h0,        32'hFFFFFFFC, 0);
    step("rst_stall",  1, 0, 0, 32'h0,        32'h0,        32'h0,        0);
    step("pre_al",     0, 1, 0, 32'h0,        32'h4,        32'h0,        0);
`ifdef PC_ALIGN_CHECK_EN
    step("mis_ld",     0, 1, 1, 32'h102,      32'h100,      32'h4,        1);
    step("mis_clr",    0, 1, 0, 32'h0,        32'h104,      32'h100,      0);
    step("mis_ld2",    0, 1, 1, 32'h203,      32'h200,      32'h104,      1);
    step("mis_hold",   0, 0, 1, 32'h1,        32'h200,      32'h104,      1);
    step("mis_rst",    1, 1, 1, 32'h3,        32'h0,        32'h0,        0);
`else
    step("raw_ld",     0, 1, 1, 32'h102,      32'h102,      32'h4,        0);
    step("raw_seq",    0, 1, 0, 32'h0,        32'h106,      32'h102,      0);
    step("raw_ld2",    0, 1, 1, 32'h203,      32'h203,      32'h106,      0);
    step("raw_hold",   0, 0, 1, 32'h1,        32'h203,      32'h106,      0);
    step("raw_rst",    1, 1, 1, 32'h3,        32'h0,        32'h0,        0);
`endif

    en = 1'b0; load = 1'b0; rst = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
